// File: rtl/matrix_store_bank.sv
// Matrix storage responder: DEPTH x DW word store with combinational read,
// synchronous write, a per-slot dimension directory and a self-clear sequencer.
module matrix_store_bank #(
  parameter int unsigned DEPTH = 400,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 32,
  parameter int unsigned SLOTS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_meta_we,
  input  logic [2:0]    i_meta_slot,
  input  logic [2:0]    i_meta_m,
  input  logic [2:0]    i_meta_n,
  input  logic [2:0]    i_meta_rslot,
  output logic [2:0]    o_meta_m,
  output logic [2:0]    o_meta_n,
  output logic          o_meta_valid,
  input  logic          i_clr_start,
  output logic          o_busy,
  output logic          o_clr_done,
  output logic          o_wr_err
);

  localparam int unsigned MW = 3;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_LIM  = AW'(DEPTH);
  localparam logic [MW-1:0] DIM_MAX   = MW'(5);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t                   state;
  logic [AW-1:0]            ptr;
  logic [DW-1:0]            mem [DEPTH];
  logic [SLOTS-1:0][MW-1:0] meta_m;
  logic [SLOTS-1:0][MW-1:0] meta_n;
  logic [SLOTS-1:0]         meta_v;

  logic idle;
  logic wr_ok;
  logic clr_go;
  logic dims_ok;

  assign idle    = (state == S_IDLE);
  assign wr_ok   = i_we && idle && (i_waddr < ADDR_LIM);
  assign clr_go  = idle && i_clr_start;
  assign dims_ok = (i_meta_m != '0) && (i_meta_m <= DIM_MAX) &&
                   (i_meta_n != '0) && (i_meta_n <= DIM_MAX);

  // Reads are gated to zero while clearing or when out of range.
  assign o_rd_data    = (o_busy || (i_rd_addr >= ADDR_LIM)) ? '0 : mem[i_rd_addr];
  assign o_meta_m     = meta_m[i_meta_rslot];
  assign o_meta_n     = meta_n[i_meta_rslot];
  assign o_meta_valid = meta_v[i_meta_rslot];

  // Storage array: the sequencer owns the write port while clearing.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Clear sequencer with registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      ptr        <= '0;
      o_busy     <= 1'b1;
      o_clr_done <= 1'b0;
      o_wr_err   <= 1'b0;
    end else begin
      o_clr_done <= 1'b0;
      o_wr_err   <= (i_we && !wr_ok) || (i_meta_we && !idle);
      case (state)
        S_CLEAR: begin
          if (ptr == LAST_ADDR) begin
            state      <= S_IDLE;
            ptr        <= '0;
            o_busy     <= 1'b0;
            o_clr_done <= 1'b1;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        S_IDLE: begin
          if (i_clr_start) begin
            state  <= S_CLEAR;
            ptr    <= '0;
            o_busy <= 1'b1;
          end
        end
        default: begin
          state  <= S_CLEAR;
          ptr    <= '0;
          o_busy <= 1'b1;
        end
      endcase
    end
  end

  // Dimension directory; starting a clear invalidates every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_m <= '0;
      meta_n <= '0;
      meta_v <= '0;
    end else if (clr_go) begin
      meta_v <= '0;
    end else if (i_meta_we && idle) begin
      meta_m[i_meta_slot] <= i_meta_m;
      meta_n[i_meta_slot] <= i_meta_n;
      meta_v[i_meta_slot] <= dims_ok;
    end
  end

endmodule
